conv_input_window_store: RTL and testbench

// - Pixel line store plus kernel-weight sequencer for the conv-layer input interface.
// - Holds BUFFER_ROW image rows. Loaded word by word from external memory during PRELOAD and LOAD.
// - Presents one full row to the interface's shift register, and emits the matching weight or bias word each cycle.
// - Driven entirely by the interface FSM's state and indices; has no FSM of its own.

---
 rtl/conv_pkg.sv | 28 ++
 rtl/conv_input_window_store_if.sv | 23 ++
 rtl/conv_weight_seq.sv | 60 ++++++
 rtl/conv_input_window_store.sv | 95 +++++++++
 tb/tb_conv_input_window_store.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/conv_pkg.sv
// Shared definitions for the conv-layer input interface: word geometry, state codes
// and the float32 constant used as the default bias.
package conv_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int KERNEL_SIZE = 3;
    localparam int IMAGE_SIZE  = 8;
    localparam int BUFFER_ROW  = 3;
    localparam int COL_W       = 4;
    localparam int ROW_W       = 2;
    localparam int KERNEL_TAPS = KERNEL_SIZE * KERNEL_SIZE;
    localparam int WIDX_W      = $clog2(KERNEL_TAPS);
    localparam int COL_SEL_W   = $clog2(IMAGE_SIZE);

    localparam logic [DATA_WIDTH-1:0] FLOAT32_ONE = 32'h3F80_0000;

    typedef logic [DATA_WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_PRELOAD = 3'd1,
        ST_SHIFT   = 3'd2,
        ST_BIAS    = 3'd3,
        ST_LOAD    = 3'd4,
        ST_IDLE    = 3'd5
    } conv_state_e;

endpackage

// File: rtl/conv_input_window_store_if.sv
// Signals between the conv interface FSM (master) and the window store (slave).
interface conv_input_window_store_if;
    import conv_pkg::*;

    logic [DATA_WIDTH-1:0]            data_in;
    logic [COL_W-1:0]                 col_index;
    logic [ROW_W-1:0]                 row_index;
    logic [ROW_W-1:0]                 preload_cycle;
    logic [2:0]                       current_state;
    logic [IMAGE_SIZE*DATA_WIDTH-1:0] data_out_bus;
    logic [DATA_WIDTH-1:0]            o_weight;

    modport master (
        output data_in, col_index, row_index, preload_cycle, current_state,
        input  data_out_bus, o_weight
    );

    modport slave (
        input  data_in, col_index, row_index, preload_cycle, current_state,
        output data_out_bus, o_weight
    );

endinterface

// File: rtl/conv_weight_seq.sv
// Kernel-weight / bias sequencer: steps through the kernel taps while shifting and
// emits the bias word in BIAS, one cycle behind the state it reflects.
module conv_weight_seq
    import conv_pkg::*;
#(
    parameter logic [KERNEL_TAPS*DATA_WIDTH-1:0] WEIGHT_INIT = '0,
    parameter logic [DATA_WIDTH-1:0]             BIAS_INIT   = FLOAT32_ONE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] state_i,
    output word_t      weight_o
);

    logic [WIDX_W-1:0] widx_q, widx_d;
    word_t             weight_q, weight_d;

    // Next tap index and next weight word from the interface state
    always_comb begin
        widx_d   = widx_q;
        weight_d = weight_q;
        case (conv_state_e'(state_i))
            ST_SHIFT: begin
                weight_d = WEIGHT_INIT[int'(widx_q)*DATA_WIDTH +: DATA_WIDTH];
                if (widx_q == WIDX_W'(KERNEL_TAPS - 1)) begin
                    widx_d = '0;
                end else begin
                    widx_d = widx_q + WIDX_W'(1);
                end
            end
            ST_BIAS: begin
                weight_d = BIAS_INIT;
                widx_d   = '0;
            end
            ST_INIT, ST_PRELOAD, ST_LOAD, ST_IDLE: begin
                weight_d = '0;
                widx_d   = '0;
            end
            default: begin
                // Unassigned codes freeze the sequencer.
                widx_d   = widx_q;
                weight_d = weight_q;
            end
        endcase
    end

    // Tap index and weight output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx_q   <= '0;
            weight_q <= '0;
        end else begin
            widx_q   <= widx_d;
            weight_q <= weight_d;
        end
    end

    assign weight_o = weight_q;

endmodule

// File: rtl/conv_input_window_store.sv
// Line store of BUFFER_ROW image rows for the conv interface, with row readout
// and the kernel-weight sequencer. Follows the interface FSM; no FSM of its own.
module conv_input_window_store
    import conv_pkg::*;
#(
    parameter logic [KERNEL_TAPS*DATA_WIDTH-1:0] WEIGHT_INIT = '0,
    parameter logic [DATA_WIDTH-1:0]             BIAS_INIT   = FLOAT32_ONE
) (
    input logic                       clk,
    input logic                       rst_n,
    conv_input_window_store_if.slave  bus
);

    localparam int LAST_ROW = BUFFER_ROW - 1;

    word_t mem_q [BUFFER_ROW][IMAGE_SIZE];
    word_t mem_d [BUFFER_ROW][IMAGE_SIZE];

    logic                             col_ok_s;
    logic [COL_SEL_W-1:0]             col_sel_s;
    logic [IMAGE_SIZE*DATA_WIDTH-1:0] row_bus_s;
    word_t                            weight_s;

    assign col_ok_s  = (bus.col_index < COL_W'(IMAGE_SIZE));
    assign col_sel_s = bus.col_index[COL_SEL_W-1:0];

    // Write decode: clear, random-access preload, or scroll-and-fill of the bottom row
    always_comb begin
        mem_d = mem_q;
        case (conv_state_e'(bus.current_state))
            ST_INIT: begin
                mem_d = '{default: '0};
            end
            ST_PRELOAD: begin
                if (col_ok_s && (bus.preload_cycle < ROW_W'(BUFFER_ROW))) begin
                    mem_d[bus.preload_cycle][col_sel_s] = bus.data_in;
                end else begin
                    mem_d = mem_q;
                end
            end
            ST_LOAD: begin
                // Column 0 of a new line also scrolls the window up by one row.
                if (bus.col_index == '0) begin
                    for (int r = 0; r < LAST_ROW; r++) begin
                        mem_d[r] = mem_q[r+1];
                    end
                    mem_d[LAST_ROW][0] = bus.data_in;
                end else if (col_ok_s) begin
                    mem_d[LAST_ROW][col_sel_s] = bus.data_in;
                end else begin
                    mem_d = mem_q;
                end
            end
            default: begin
                mem_d = mem_q;
            end
        endcase
    end

    // Line-store registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Row readout, column 0 in the most significant word
    always_comb begin
        row_bus_s = '0;
        if (bus.row_index < ROW_W'(BUFFER_ROW)) begin
            for (int c = 0; c < IMAGE_SIZE; c++) begin
                row_bus_s[(IMAGE_SIZE-c)*DATA_WIDTH-1 -: DATA_WIDTH] = mem_q[bus.row_index][c];
            end
        end else begin
            row_bus_s = '0;
        end
    end

    assign bus.data_out_bus = row_bus_s;

    conv_weight_seq #(
        .WEIGHT_INIT (WEIGHT_INIT),
        .BIAS_INIT   (BIAS_INIT)
    ) u_weight_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .state_i  (bus.current_state),
        .weight_o (weight_s)
    );

    assign bus.o_weight = weight_s;

endmodule

// File: tb/tb_conv_input_window_store.sv
// Directed bench for conv_input_window_store: preload, scroll-load, weight/bias
// sequencing, out-of-range indices and asynchronous reset mid-operation.
module tb_conv_input_window_store;
    import conv_pkg::*;

    localparam logic [KERNEL_TAPS*DATA_WIDTH-1:0] W_INIT =
        {32'd9, 32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    conv_input_window_store_if bus_if ();

    conv_input_window_store #(
        .WEIGHT_INIT (W_INIT),
        .BIAS_INIT   (32'h3F80_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Row of consecutive {row,col} codes starting at base, col 0 in the MSB word.
    function automatic logic [IMAGE_SIZE*DATA_WIDTH-1:0] row_code(input logic [31:0] base);
        logic [IMAGE_SIZE*DATA_WIDTH-1:0] v;
        v = '0;
        for (int c = 0; c < IMAGE_SIZE; c++) begin
            v[(IMAGE_SIZE-c)*DATA_WIDTH-1 -: DATA_WIDTH] = base + 32'(c);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [IMAGE_SIZE*DATA_WIDTH-1:0] obs,
                         input logic [IMAGE_SIZE*DATA_WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag, input logic [1:0] row,
                             input logic [IMAGE_SIZE*DATA_WIDTH-1:0] exp);
        bus_if.row_index = row;
        #1;
        check(tag, bus_if.data_out_bus, exp);
    endtask

    task automatic check_w(input string tag, input logic [31:0] exp);
        check(tag, {224'd0, bus_if.o_weight}, {224'd0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input conv_state_e st, input logic [1:0] pc,
                         input logic [3:0] col, input logic [31:0] d);
        bus_if.current_state = st;
        bus_if.preload_cycle = pc;
        bus_if.col_index     = col;
        bus_if.data_in       = d;
        step();
    endtask

    task automatic preload_all(input logic [31:0] base);
        for (int r = 0; r < BUFFER_ROW; r++) begin
            for (int c = 0; c < IMAGE_SIZE; c++) begin
                drive(ST_PRELOAD, 2'(r), 4'(c), base + 32'(r*256 + c));
            end
        end
    endtask

    initial begin
        logic [IMAGE_SIZE*DATA_WIDTH-1:0] part;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus_if.current_state = ST_IDLE;
        bus_if.preload_cycle = 2'd0;
        bus_if.col_index     = 4'd0;
        bus_if.row_index     = 2'd0;
        bus_if.data_in       = 32'd0;

        // Reset state
        step();
        check_row("rst_row0", 2'd0, '0);
        check_w("rst_w", 32'd0);
        step();
        rst_n = 1'b1;
        drive(ST_INIT, 2'd0, 4'd0, 32'hFFFF_FFFF);
        check_row("init_row0", 2'd0, '0);
        check_row("init_row1", 2'd1, '0);
        check_row("init_row2", 2'd2, '0);
        check_w("init_w", 32'd0);

        // Preload rows with {row,col} codes
        preload_all(32'h0000_0000);
        check_row("pre_row0", 2'd0, row_code(32'h0000_0000));
        check_row("pre_row1", 2'd1, row_code(32'h0000_0100));
        check_row("pre_row2", 2'd2, row_code(32'h0000_0200));
        check_row("row_idx3", 2'd3, '0);

        // Out-of-range preload indices write nothing
        drive(ST_PRELOAD, 2'd0, 4'd8, 32'hDEAD_BEEF);
        drive(ST_PRELOAD, 2'd3, 4'd1, 32'hCAFE_F00D);
        check_row("pre_col8_row0", 2'd0, row_code(32'h0000_0000));
        check_row("pre_pc3_row1", 2'd1, row_code(32'h0000_0100));
        check_row("pre_pc3_row2", 2'd2, row_code(32'h0000_0200));

        // Load: column 0 scrolls and fills the bottom row's first word
        drive(ST_LOAD, 2'd0, 4'd0, 32'h0000_0300);
        part = row_code(32'h0000_0200);
        part[IMAGE_SIZE*DATA_WIDTH-1 -: DATA_WIDTH] = 32'h0000_0300;
        check_row("load0_row0", 2'd0, row_code(32'h0000_0100));
        check_row("load0_row1", 2'd1, row_code(32'h0000_0200));
        check_row("load0_row2", 2'd2, part);
        for (int c = 1; c < IMAGE_SIZE; c++) begin
            drive(ST_LOAD, 2'd0, 4'(c), 32'h0000_0300 + 32'(c));
        end
        drive(ST_LOAD, 2'd0, 4'd8, 32'hDEAD_BEEF);
        check_row("load_row0", 2'd0, row_code(32'h0000_0100));
        check_row("load_row1", 2'd1, row_code(32'h0000_0200));
        check_row("load_row2", 2'd2, row_code(32'h0000_0300));
        check_w("load_w", 32'd0);

        // Weight sequence 1..9, wrap, bias, idle
        for (int i = 0; i < KERNEL_TAPS; i++) begin
            drive(ST_SHIFT, 2'd0, 4'd0, 32'd0);
            check_w($sformatf("shift_w%0d", i), 32'(i + 1));
        end
        drive(ST_SHIFT, 2'd0, 4'd0, 32'd0);
        check_w("shift_wrap", 32'd1);
        drive(ST_BIAS, 2'd0, 4'd0, 32'd0);
        check_w("bias_w", 32'h3F80_0000);
        check_row("shift_hold_row2", 2'd2, row_code(32'h0000_0300));
        drive(ST_SHIFT, 2'd0, 4'd0, 32'd0);
        check_w("after_bias_w", 32'd1);
        drive(ST_SHIFT, 2'd0, 4'd0, 32'd0);
        check_w("after_bias_w2", 32'd2);
        drive(ST_IDLE, 2'd0, 4'd0, 32'd0);
        check_w("idle_w", 32'd0);

        // Unassigned state code holds the weight sequencer and memory
        drive(ST_SHIFT, 2'd0, 4'd0, 32'd0);
        bus_if.current_state = 3'd6;
        bus_if.col_index     = 4'd0;
        bus_if.data_in       = 32'h1234_5678;
        step();
        check_w("code6_hold", 32'd1);
        drive(ST_SHIFT, 2'd0, 4'd0, 32'd0);
        check_w("code6_widx", 32'd2);

        // Reset mid-SHIFT clears the weight at once
        bus_if.current_state = ST_SHIFT;
        rst_n = 1'b0;
        #1;
        check_w("rst_shift_w", 32'd0);
        step();
        rst_n = 1'b1;

        // Reset mid-LOAD at column 4
        preload_all(32'h0000_0000);
        for (int c = 0; c < 4; c++) begin
            drive(ST_LOAD, 2'd0, 4'(c), 32'h0000_0300 + 32'(c));
        end
        bus_if.col_index = 4'd4;
        bus_if.data_in   = 32'h0000_0304;
        rst_n = 1'b0;
        check_row("rst_load_row0", 2'd0, '0);
        check_row("rst_load_row1", 2'd1, '0);
        check_row("rst_load_row2", 2'd2, '0);
        check_w("rst_load_w", 32'd0);
        step();
        bus_if.current_state = ST_IDLE;
        rst_n = 1'b1;
        step();
        check_row("post_rst_row2", 2'd2, '0);

        // Refill after reset
        preload_all(32'h0000_0A00);
        check_row("refill_row0", 2'd0, row_code(32'h0000_0A00));
        check_row("refill_row1", 2'd1, row_code(32'h0000_0B00));
        check_row("refill_row2", 2'd2, row_code(32'h0000_0C00));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
